// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator for the pipelined core.
//
// Each cycle it produces the registered fetch PC. A direct-mapped branch target buffer (BTB)
// with 2-bit saturating counters predicts taken branches. The unit also takes redirects from
// execute and from the trap unit, and keeps a saturating count of execute mispredicts.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold the current PC
//   ex_redirect    in   execute-stage mispredict correction
//   ex_target      in   corrected PC
//   trap           in   trap/exception request (highest priority)
//   trap_vector    in   trap handler address
//   upd_valid      in   BTB update strobe for a resolved branch
//   upd_pc         in   PC of the resolved branch
//   upd_target     in   resolved branch target
//   upd_taken      in   resolved branch outcome
//   pc             out  current fetch PC (registered)
//   pred_taken     out  BTB predicts the current pc as taken
//   pred_target    out  predicted target for the current pc (0 on miss)
//   mispredict_cnt out  saturating count of ex_redirect cycles

module pc_gen #(
   parameter int unsigned ADDRESS_WIDTH = 12,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int unsigned BTB_ENTRIES = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall,
   input  logic                     ex_redirect,
   input  logic [ADDRESS_WIDTH-1:0] ex_target,
   input  logic                     trap,
   input  logic [ADDRESS_WIDTH-1:0] trap_vector,
   input  logic                     upd_valid,
   input  logic [ADDRESS_WIDTH-1:0] upd_pc,
   input  logic [ADDRESS_WIDTH-1:0] upd_target,
   input  logic                     upd_taken,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic                     pred_taken,
   output logic [ADDRESS_WIDTH-1:0] pred_target,
   output logic [CNT_WIDTH-1:0]     mispredict_cnt
);

   localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = ADDRESS_WIDTH - IDX - 2;

   // Word-align an address; every address loaded into pc passes through here.
   function automatic logic [ADDRESS_WIDTH-1:0] align(input logic [ADDRESS_WIDTH-1:0] a);
      return a & ~ADDRESS_WIDTH'(3);
   endfunction

   logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

   logic                     btb_valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0]         btb_tag_q    [BTB_ENTRIES];
   logic [ADDRESS_WIDTH-1:0] btb_target_q [BTB_ENTRIES];
   logic [1:0]               btb_ctr_q    [BTB_ENTRIES];

   // Lookup on the registered pc
   logic [IDX-1:0]   look_idx;
   logic [TAG_W-1:0] look_tag;
   logic             look_hit;

   assign look_idx = pc_q[IDX+1:2];
   assign look_tag = pc_q[ADDRESS_WIDTH-1:IDX+2];
   assign look_hit = btb_valid_q[look_idx] && (btb_tag_q[look_idx] == look_tag);

   assign pred_taken  = look_hit && btb_ctr_q[look_idx][1];
   assign pred_target = look_hit ? btb_target_q[look_idx] : '0;

   // Update-side decode
   logic [IDX-1:0]   upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic             unused_upd_pc_lsb;

   assign upd_idx           = upd_pc[IDX+1:2];
   assign upd_tag           = upd_pc[ADDRESS_WIDTH-1:IDX+2];
   assign upd_hit           = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);
   assign unused_upd_pc_lsb = ^upd_pc[1:0];

   // Next-PC selection, highest priority first
   always_comb begin
      pc_d = pc_q + ADDRESS_WIDTH'(4);
      if (trap) begin
         pc_d = align(trap_vector);
      end else if (ex_redirect) begin
         pc_d = align(ex_target);
      end else if (stall) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = align(pred_target);
      end
   end

   // Counts every redirect, even when a trap wins the PC mux
   always_comb begin
      cnt_d = cnt_q;
      if (ex_redirect && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
      end
   end

   // BTB storage; lookups this cycle see the old contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
            btb_valid_q[i]  <= 1'b0;
            btb_tag_q[i]    <= '0;
            btb_target_q[i] <= '0;
            btb_ctr_q[i]    <= 2'b00;
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               btb_target_q[upd_idx] <= align(upd_target);
               if (btb_ctr_q[upd_idx] != 2'b11) begin
                  btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] + 2'b01;
               end
            end else if (btb_ctr_q[upd_idx] != 2'b00) begin
               btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] - 2'b01;
            end
         end else if (upd_taken) begin
            // Allocate (or evict) with weakly-taken confidence
            btb_valid_q[upd_idx]  <= 1'b1;
            btb_tag_q[upd_idx]    <= upd_tag;
            btb_target_q[upd_idx] <= align(upd_target);
            btb_ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

   assign pc             = pc_q;
   assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        ex_redirect;
   logic [11:0] ex_target;
   logic        trap;
   logic [11:0] trap_vector;
   logic        upd_valid;
   logic [11:0] upd_pc;
   logic [11:0] upd_target;
   logic        upd_taken;
   logic [11:0] pc, pc2;
   logic        pred_taken, pred_taken2;
   logic [11:0] pred_target, pred_target2;
   logic [15:0] mispredict_cnt;
   logic [1:0]  mispredict_cnt2;

   int checks = 0;
   int errors = 0;

   pc_gen #(.ADDRESS_WIDTH(12), .RESET_VECTOR(12'h000), .BTB_ENTRIES(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
      .ex_target(ex_target), .trap(trap), .trap_vector(trap_vector),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .pc(pc), .pred_taken(pred_taken),
      .pred_target(pred_target), .mispredict_cnt(mispredict_cnt)
   );

   // Same stimulus, narrow counter to exercise saturation
   pc_gen #(.ADDRESS_WIDTH(12), .RESET_VECTOR(12'h000), .BTB_ENTRIES(8), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_redirect(ex_redirect),
      .ex_target(ex_target), .trap(trap), .trap_vector(trap_vector),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .pc(pc2), .pred_taken(pred_taken2),
      .pred_target(pred_target2), .mispredict_cnt(mispredict_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
      trap = 1'b0; trap_vector = '0; upd_valid = 1'b0; upd_pc = '0;
      upd_target = '0; upd_taken = 1'b0;

      // Reset state
      tick();
      chk("rst_pc", 32'(pc), 32'h000);
      chk("rst_pred_taken", 32'(pred_taken), 32'h0);
      chk("rst_pred_target", 32'(pred_target), 32'h000);
      chk("rst_cnt", 32'(mispredict_cnt), 32'h0);
      rst_n = 1'b1;
      tick(); chk("seq_4", 32'(pc), 32'h004);
      tick(); chk("seq_8", 32'(pc), 32'h008);
      tick(); chk("seq_c", 32'(pc), 32'h00C);

      // Asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pc", 32'(pc), 32'h000);
      chk("async_rst_pred", 32'(pred_taken), 32'h0);
      #1 rst_n = 1'b1;
      chk("rel_pc0", 32'(pc), 32'h000);
      tick(); chk("rel_pc4", 32'(pc), 32'h004);
      tick(); chk("rel_pc8", 32'(pc), 32'h008);
      tick();
      tick(); chk("pre_stall", 32'(pc), 32'h010);

      // Stall
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); chk("stall_hold", 32'(pc), 32'h010);
      end
      stall = 1'b0;
      tick(); chk("unstall_14", 32'(pc), 32'h014);
      tick(); chk("unstall_18", 32'(pc), 32'h018);

      // BTB allocate and predict
      upd_valid = 1'b1; upd_pc = 12'h020; upd_target = 12'h100; upd_taken = 1'b1;
      tick(); upd_valid = 1'b0;
      chk("alloc_pc1c", 32'(pc), 32'h01C);
      chk("alloc_nopred_1c", 32'(pred_taken), 32'h0);
      tick();
      chk("pred_pc20", 32'(pc), 32'h020);
      chk("pred_taken_20", 32'(pred_taken), 32'h1);
      chk("pred_target_20", 32'(pred_target), 32'h100);
      tick(); chk("pred_jump", 32'(pc), 32'h100);

      // Same index, different tag
      trap = 1'b1; trap_vector = 12'h220;
      tick(); trap = 1'b0;
      chk("alias_pc", 32'(pc), 32'h220);
      chk("alias_pred_taken", 32'(pred_taken), 32'h0);
      chk("alias_pred_target", 32'(pred_target), 32'h000);

      // Counter training: 10 -> 01 no longer predicts taken
      upd_valid = 1'b1; upd_pc = 12'h020; upd_target = 12'h000; upd_taken = 1'b0;
      tick(); upd_valid = 1'b0;
      trap = 1'b1; trap_vector = 12'h020;
      tick(); trap = 1'b0;
      chk("weak_nt_pc", 32'(pc), 32'h020);
      chk("weak_nt_pred", 32'(pred_taken), 32'h0);
      tick(); chk("weak_nt_next", 32'(pc), 32'h024);

      // Two taken updates: 01 -> 11
      upd_valid = 1'b1; upd_pc = 12'h020; upd_target = 12'h100; upd_taken = 1'b1;
      tick(); tick(); upd_valid = 1'b0;
      trap = 1'b1; trap_vector = 12'h020;
      tick(); trap = 1'b0;
      chk("trained_pred", 32'(pred_taken), 32'h1);
      chk("trained_target", 32'(pred_target), 32'h100);

      // Third taken update in the lookup cycle: next pc still uses the old target
      upd_valid = 1'b1; upd_pc = 12'h020; upd_target = 12'h140; upd_taken = 1'b1;
      tick();
      chk("same_cycle_old", 32'(pc), 32'h100);
      // One not-taken: saturated 11 -> 10 still predicts taken
      upd_taken = 1'b0;
      tick(); upd_valid = 1'b0;
      chk("miss_seq_104", 32'(pc), 32'h104);
      trap = 1'b1; trap_vector = 12'h020;
      tick(); trap = 1'b0;
      chk("sat_pred", 32'(pred_taken), 32'h1);
      chk("new_target", 32'(pred_target), 32'h140);
      tick(); chk("new_target_jump", 32'(pc), 32'h140);

      // Priority: trap > redirect > stall
      trap = 1'b1; trap_vector = 12'h040;
      tick(); chk("prio_pre", 32'(pc), 32'h040);
      trap_vector = 12'h203; ex_redirect = 1'b1; ex_target = 12'h083; stall = 1'b1;
      tick();
      chk("prio_trap", 32'(pc), 32'h200);
      chk("prio_cnt1", 32'(mispredict_cnt), 32'h1);
      trap = 1'b0;
      tick();
      chk("prio_redirect", 32'(pc), 32'h080);
      chk("prio_cnt2", 32'(mispredict_cnt), 32'h2);
      chk("prio_cnt2_narrow", 32'(mispredict_cnt2), 32'h2);

      // Wrap
      stall = 1'b0; ex_target = 12'hFFC;
      tick(); ex_redirect = 1'b0;
      chk("wrap_ffc", 32'(pc), 32'hFFC);
      tick(); chk("wrap_000", 32'(pc), 32'h000);

      // Counter saturation on the 2-bit instance
      ex_redirect = 1'b1; ex_target = 12'h300;
      for (int i = 0; i < 5; i++) tick();
      ex_redirect = 1'b0;
      chk("redir_pc", 32'(pc), 32'h300);
      chk("cnt_wide", 32'(mispredict_cnt), 32'h8);
      chk("cnt_sat", 32'(mispredict_cnt2), 32'h3);

      // Reset clears counter and BTB
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_cnt", 32'(mispredict_cnt), 32'h0);
      #1 rst_n = 1'b1;
      trap = 1'b1; trap_vector = 12'h020;
      tick(); trap = 1'b0;
      chk("rst2_btb_clear", 32'(pred_taken), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the single-cycle PC register for the pipelined core.
- Generates the fetch PC each cycle and holds it under stall.
- Accepts redirects from execute (mispredict) and from the trap unit.
- Predicts taken branches with an internal direct-mapped branch target buffer (BTB) using 2-bit saturating counters, and counts mispredicts.

Parameters:
- ADDRESS_WIDTH, 12, width of the PC and of all addresses.
- RESET_VECTOR, 0, PC value loaded on reset. Bits [1:0] must be 0.
- BTB_ENTRIES, 8, number of BTB entries. Power of two, at least 2. Requires ADDRESS_WIDTH > log2(BTB_ENTRIES)+2.
- CNT_WIDTH, 16, width of the mispredict counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the current PC.
- ex_redirect  in  1  execute-stage mispredict correction.
- ex_target  in  ADDRESS_WIDTH  corrected PC.
- trap  in  1  trap/exception request.
- trap_vector  in  ADDRESS_WIDTH  trap handler address.
- upd_valid  in  1  BTB update strobe from execute (resolved branch).
- upd_pc  in  ADDRESS_WIDTH  PC of the resolved branch.
- upd_target  in  ADDRESS_WIDTH  resolved branch target.
- upd_taken  in  1  resolved branch outcome.
- pc  out  ADDRESS_WIDTH  current fetch PC (registered).
- pred_taken  out  1  BTB predicts the current pc as taken.
- pred_target  out  ADDRESS_WIDTH  predicted target for the current pc.
- mispredict_cnt  out  CNT_WIDTH  saturating count of ex_redirect cycles.

Behaviour:
- Reset is fixed: clk is the single clock; rst_n is asynchronous and active-low.
- While rst_n=0, and immediately when it asserts (including mid-operation):
  - pc=RESET_VECTOR, mispredict_cnt=0;
  - all BTB valid bits=0 and counters=2'b00, so pred_taken=0 and pred_target=0.
- BTB addressing:
  - index = pc[IDX+1:2], with IDX=log2(BTB_ENTRIES);
  - tag = pc[ADDRESS_WIDTH-1:IDX+2];
  - each entry holds valid, tag, target and a 2-bit counter.
- Lookup is combinational on the registered pc:
  - hit = valid and tag match;
  - pred_taken = hit and counter[1];
  - pred_target = the entry target when hit, else 0.
- Next PC, in strict priority order:
  1. trap → trap_vector;
  2. ex_redirect → ex_target;
  3. stall → pc (hold);
  4. pred_taken → pred_target;
  5. otherwise pc+4.
- trap and ex_redirect override stall.
- All loaded addresses have bits [1:0] forced to 0.
- pc+4 wraps modulo 2^ADDRESS_WIDTH.
- BTB update, applied on the clock edge when upd_valid=1. Indexing/tagging uses upd_pc.
  - Hit, taken: counter increments, saturating at 2'b11; target is overwritten with upd_target.
  - Hit, not taken: counter decrements, saturating at 2'b00; valid stays 1.
  - Miss, taken: allocate/replace the entry with valid=1, the new tag, upd_target, counter=2'b10.
  - Miss, not taken: no change.
- Updates are independent of stall, trap and redirect.
- A lookup in the same cycle as an update to the same entry sees the old contents. The new contents are visible from the next cycle.
- mispredict_cnt increments on every clock edge where ex_redirect=1, including when trap wins priority. It saturates at all-ones.
- Latency: one cycle from any redirect input to pc.

Test Plan:
- Reset:
  - Run to pc=0x00C, then drop rst_n asynchronously between edges → pc=0x000 with no clock edge, pred_taken=0.
  - Release → pc sequence 0x000, 0x004, 0x008.
- Stall:
  - At pc=0x010 hold stall=1 for 3 cycles → pc stays 0x010.
  - Deassert → 0x014, then 0x018.
- BTB allocate and predict:
  - upd_valid with upd_pc=0x020, upd_target=0x100, upd_taken=1 → when pc reaches 0x020: pred_taken=1, pred_target=0x100, next pc=0x100.
  - pc=0x220 (same index, different tag) → pred_taken=0.
- Counter training:
  - After allocation (2'b10), one not-taken update for 0x020 → counter 2'b01, pred_taken=0 at 0x020, next pc=0x024.
  - Two taken updates → counter 2'b11, predicted again.
  - A third taken update keeps the counter at 2'b11.
- Priority:
  - At pc=0x040 assert trap (vector 0x200), ex_redirect (target 0x080) and stall together → pc=0x200.
  - Next cycle, ex_redirect (target 0x080) plus stall → pc=0x080.
  - mispredict_cnt increases by 2.
- Wrap and saturation:
  - ex_redirect to 0xFFC, then no inputs → pc 0xFFC then 0x000.
  - With CNT_WIDTH=2, five ex_redirect cycles → mispredict_cnt=3.
